// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module      : inst_fetch_ctrl_pkg
// Description : Shared definitions for the instruction fetch controller.
//               Default data/address width, default reset PC and the
//               fetch FSM state encoding.
// Revision    : 1.0 - initial release
// =============================================================================
package inst_fetch_ctrl_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch FSM encoding (3 bits, five states)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_HOLD = ST_HOLD,
        S_DROP = ST_DROP
    } fetch_state_t;

endpackage : inst_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module      : inst_fetch_ctrl_if
// Description : Bundle of the fetch controller's bus signals.
//               redirect_valid/redirect_pc : next-PC override from PC calc
//               mem_cen/mem_wen/mem_addr   : I-mem request (word address)
//               mem_rdata/mem_stall        : I-mem response
//               inst_valid/inst/inst_pc    : fetched instruction to decode
//               inst_ready                 : decode accepts this cycle
//               master = fetch controller, slave = its environment.
// Revision    : 1.0 - initial release
// =============================================================================
interface inst_fetch_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_cen;
    logic            mem_wen;
    logic [XLEN-3:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_stall;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output mem_cen, mem_wen, mem_addr,
        input  mem_rdata, mem_stall,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_cen, mem_wen, mem_addr,
        output mem_rdata, mem_stall,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface : inst_fetch_ctrl_if
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : inst_fetch_ctrl
// Description : Instruction fetch controller. Owns the architectural PC,
//               issues single-beat I-mem reads, waits out stalls and
//               presents the fetched word plus its PC to decode through a
//               valid/ready handshake. Redirects override the PC at any
//               point; an in-flight read is drained and discarded.
// Ports       : clk  - core clock (rising edge)
//               rst  - synchronous active-high reset
//               bus  - inst_fetch_ctrl_if.master (redirect, I-mem, decode)
// Revision    : 1.0 - initial release
// =============================================================================
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  wire                   clk,
    input  wire                   rst,
    inst_fetch_ctrl_if.master     bus
);

    localparam logic [XLEN-1:0] C_PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_inst_valid;
    logic            w_inst_valid_nxt;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            w_capture;
    logic [XLEN-1:0] w_redirect_aligned;

    assign w_redirect_aligned = bus.redirect_pc & C_ALIGN_MASK;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // PC register and instruction buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            if (w_capture) begin
                r_inst    <= bus.mem_rdata;
                r_inst_pc <= r_pc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-PC logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_capture        = 1'b0;

        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.mem_stall) begin
                    w_capture        = 1'b1;
                    w_inst_valid_nxt = 1'b1;
                    w_state_nxt      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.inst_ready) begin
                    w_pc_nxt         = r_pc + C_PC_STEP;  // wraps modulo 2^XLEN
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_REQ;
                end
            end
            S_DROP: begin
                if (!bus.mem_stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A redirect overrides everything above. Any buffered or in-flight
        // instruction is discarded; a read still in progress must be drained
        // in DROP so that only one request is ever outstanding. A response
        // that completes in the redirect cycle itself has already drained,
        // so the FSM can go straight to REQ (from WAIT or DROP alike).
        if (bus.redirect_valid) begin
            w_pc_nxt         = w_redirect_aligned;
            w_capture        = 1'b0;
            w_inst_valid_nxt = 1'b0;
            case (r_state)
                S_REQ:   w_state_nxt = S_DROP;
                S_WAIT:  w_state_nxt = bus.mem_stall ? S_DROP : S_REQ;
                S_DROP:  w_state_nxt = bus.mem_stall ? S_DROP : S_REQ;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.mem_cen    = (r_state == S_REQ);
    assign bus.mem_wen    = 1'b0;
    assign bus.mem_addr   = r_pc[XLEN-1:2];
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;

endmodule : inst_fetch_ctrl
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_inst_fetch_ctrl
// Description : Self-checking bench for inst_fetch_ctrl. A behavioural
//               I-mem with programmable stall answers each request; every
//               request pushes its expected {pc, word} into a scoreboard
//               that is popped on each decode handshake.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_JUNK   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_ctrl_if #(.XLEN(XLEN)) bus ();

    inst_fetch_ctrl #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: a simple function of the word address
    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return {wa, 2'b01} ^ 32'h5A3C_0F00;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] model_pc   = RESET_PC;
    int          stall_cfg  = 0;
    bit          pending    = 1'b0;
    logic [29:0] p_addr     = '0;
    int          stall_left = 0;
    int          req_stall  = 0;
    int          cyc        = 0;
    int          cen_cyc    = 0;
    int          cen_cnt    = 0;
    int          accept_cnt = 0;
    logic [31:0] last_pc    = '0;
    logic [29:0] last_addr  = '0;
    bit          prev_rst   = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_hold  = 1'b0;
    bit          prev_acc   = 1'b0;
    logic [31:0] hold_inst  = '0;
    logic [31:0] hold_pc    = '0;
    bit          acc;

    // -------------------------------------------------------------------------
    // Memory model + monitor + scoreboard, all on the falling edge
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;

        // Response for the current cycle (a request seen last cycle is now in WAIT)
        if (pending) begin
            if (stall_left > 0) begin
                bus.mem_stall = 1'b1;
                bus.mem_rdata = C_JUNK;
                stall_left--;
            end else begin
                bus.mem_stall = 1'b0;
                bus.mem_rdata = mem_word(p_addr);
                pending       = 1'b0;
            end
        end else begin
            bus.mem_stall = 1'b0;
            bus.mem_rdata = C_JUNK;
        end

        if (prev_rst) begin
            chk("rst_cen",    64'(bus.mem_cen),    64'(0));
            chk("rst_valid",  64'(bus.inst_valid), 64'(0));
            chk("rst_inst",   64'(bus.inst),       64'(0));
            chk("rst_instpc", 64'(bus.inst_pc),    64'(0));
            chk("rst_addr",   64'(bus.mem_addr),   64'(RESET_PC[31:2]));
        end else begin
            if (prev_hold) begin
                chk("hold_valid",  64'(bus.inst_valid), 64'(1));
                chk("hold_inst",   64'(bus.inst),       64'(hold_inst));
                chk("hold_instpc", 64'(bus.inst_pc),    64'(hold_pc));
            end
            if (prev_acc)
                chk("req_after_accept", 64'(bus.mem_cen), 64'(1));
            if (bus.inst_valid)
                chk("no_cen_while_valid", 64'(bus.mem_cen), 64'(0));
            if (bus.inst_valid && !prev_valid)
                chk("latency", 64'(cyc - cen_cyc), 64'(2 + req_stall));
        end

        if (bus.mem_cen) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(model_pc[31:2]));
            chk("mem_wen",  64'(bus.mem_wen),  64'(0));
            sb.push_back('{pc: model_pc, word: mem_word(model_pc[31:2])});
            pending    = 1'b1;
            p_addr     = bus.mem_addr;
            stall_left = stall_cfg;
            req_stall  = stall_cfg;
            cen_cyc    = cyc;
            last_addr  = bus.mem_addr;
            cen_cnt++;
        end

        acc = bus.inst_valid && bus.inst_ready;
        if (acc) begin
            if (sb.size() == 0) begin
                chk("sb_empty_on_accept", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("inst_pc", 64'(bus.inst_pc), 64'(e.pc));
                chk("inst",    64'(bus.inst),    64'(e.word));
            end
            last_pc = bus.inst_pc;
            accept_cnt++;
        end

        if (bus.redirect_valid) begin
            if (!acc) sb.delete();
            model_pc = bus.redirect_pc & ~32'h3;
        end else if (acc) begin
            model_pc = model_pc + 32'd4;
        end

        if (rst) begin
            sb.delete();
            model_pc = RESET_PC;
        end

        prev_hold  = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid && !rst;
        prev_acc   = acc && !rst;
        prev_valid = bus.inst_valid;
        prev_rst   = rst;
        hold_inst  = bus.inst;
        hold_pc    = bus.inst_pc;
    end

    // -------------------------------------------------------------------------
    // Bounded waits (inputs change #1 after the rising edge)
    // -------------------------------------------------------------------------
    task automatic wait_accepts(input int n, input string tag);
        int target;
        target = accept_cnt + n;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (accept_cnt >= target) return;
        end
        chk({"timeout_", tag}, 64'(0), 64'(1));
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bus.inst_valid) return;
        end
        chk({"timeout_", tag}, 64'(0), 64'(1));
    endtask

    task automatic wait_cen(input int base, input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (cen_cnt > base) return;
        end
        chk({"timeout_", tag}, 64'(0), 64'(1));
    endtask

    task automatic redirect_pulse(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int c0;

    initial begin
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        rst                = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: back-to-back fetches of 0x0 and 0x4, no stall
        wait_accepts(2, "seq");
        chk("seq_last_pc", 64'(last_pc), 64'(32'h4));

        // 2: fetch of 0x8 stalled for 5 cycles
        stall_cfg = 5;
        c0 = cen_cnt;
        wait_accepts(1, "stall");
        stall_cfg = 0;
        chk("stall_one_cen", 64'(cen_cnt - c0), 64'(1));
        chk("stall_pc",      64'(last_pc),      64'(32'h8));

        // 3: decode back-pressure in HOLD
        bus.inst_ready = 1'b0;
        wait_valid("bp");
        c0 = cen_cnt;
        repeat (3) @(posedge clk);
        #1 bus.inst_ready = 1'b1;
        wait_accepts(1, "bp");
        chk("bp_no_cen", 64'(cen_cnt - c0), 64'(0));
        chk("bp_pc",     64'(last_pc),      64'(32'hC));

        // 4: redirect to unaligned 0x103 while WAIT is stalled
        stall_cfg = 4;
        c0 = cen_cnt;
        wait_cen(c0, "redir_wait");
        stall_cfg = 0;
        redirect_pulse(32'h0000_0103);
        wait_accepts(1, "redir_wait");
        chk("redir_wait_pc",   64'(last_pc),   64'(32'h100));
        chk("redir_wait_addr", 64'(last_addr), 64'(30'h40));

        // 5: redirect to 0x200 with ready=1 in HOLD (0x104 is accepted)
        wait_valid("redir_hold");
        redirect_pulse(32'h0000_0200);
        chk("redir_hold_valid_fall", 64'(bus.inst_valid), 64'(0));
        chk("redir_hold_acc_pc",     64'(last_pc),        64'(32'h104));
        wait_accepts(1, "redir_hold");
        chk("redir_hold_pc", 64'(last_pc), 64'(32'h200));

        // 6a: PC wrap from 0xFFFFFFFC to 0x0
        wait_valid("wrap");
        redirect_pulse(32'hFFFF_FFFC);
        wait_accepts(1, "wrap_top");
        chk("wrap_top_pc", 64'(last_pc), 64'(32'hFFFF_FFFC));
        wait_accepts(1, "wrap_zero");
        chk("wrap_zero_pc",   64'(last_pc),   64'(32'h0));
        chk("wrap_zero_addr", 64'(last_addr), 64'(30'h0));

        // 6b: reset while WAIT is stalled, then fetch restarts at RESET_PC
        stall_cfg = 5;
        c0 = cen_cnt;
        wait_cen(c0, "rst_wait");
        stall_cfg = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_valid", 64'(bus.inst_valid), 64'(0));
        chk("rst_mid_cen",   64'(bus.mem_cen),    64'(0));
        wait_accepts(2, "after_rst");
        chk("after_rst_pc", 64'(last_pc), 64'(RESET_PC + 32'h4));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_inst_fetch_ctrl
`default_nettype wire
